// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Pulls bytes one at a time from an upstream FIFO and sends each one as an
// 8N1 serial frame: start bit (0), eight data bits LSB first, stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles. The FIFO is read with a
// single registered strobe. Its data is captured one cycle later into a
// shift register, so the FIFO is free to move on while the frame is sent.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//
// Ports
//   clk        : system clock, rising-edge active
//   rst        : synchronous active-high reset
//   fifo_empt  : upstream FIFO empty flag (registered in the FIFO)
//   fifo_data  : upstream FIFO read data, valid the cycle after rd_en
//   fifo_rd_en : registered read strobe to the FIFO, one pulse per frame
//   tx         : registered serial output, idles high
//   busy       : high whenever a fetch or frame is in progress
//   tx_done    : one-cycle pulse in the final cycle of the stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empt,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] CNT_LOAD = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        tx_nxt;
  logic        rd_en_nxt;

  // State register plus the datapath and output registers. tx and fifo_rd_en
  // are registered copies of values computed from the next state, so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      tx         <= tx_nxt;
      fifo_rd_en <= rd_en_nxt;
    end
  end

  // Next-state and datapath update. The FIFO empty flag is looked at only in
  // IDLE, and FIFO data is looked at only when leaving WAIT. Because of this,
  // the single read pulse per frame has settled long before the flag is
  // sampled again.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    case (state)
      IDLE: begin
        if (!fifo_empt) state_nxt = REQ;
      end
      REQ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = START;
        shift_nxt = fifo_data;
        cnt_nxt   = CNT_LOAD;
      end
      START: begin
        if (cnt == 16'd0) begin
          state_nxt   = DATA;
          cnt_nxt     = CNT_LOAD;
          bit_idx_nxt = 3'd0;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          cnt_nxt = CNT_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt   = STOP;
            bit_idx_nxt = 3'd0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == 16'd0) state_nxt = IDLE;
        else              cnt_nxt   = cnt - 16'd1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs. The registered outputs are computed from the upcoming state.
  // While in DATA, the current bit always sits in shift[0].
  always_comb begin
    rd_en_nxt = (state_nxt == REQ);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
    busy    = (state != IDLE);
    tx_done = (state == STOP) && (cnt == 16'd0);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx. Two instances are used: dut_a with
// CLKS_PER_BIT=4 and dut_b with CLKS_PER_BIT=2. Each instance has its own
// small FIFO model: a byte queue with a registered empty flag and read data
// that appears the cycle after the read strobe. Expected serial frames are
// built from the byte being sent.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       fifo_empt_a = 1'b1;
  logic [7:0] fifo_data_a = 8'h00;
  logic       fifo_rd_en_a, tx_a, busy_a, tx_done_a;
  logic [7:0] q_a[$];

  logic       fifo_empt_b = 1'b1;
  logic [7:0] fifo_data_b = 8'h00;
  logic       fifo_rd_en_b, tx_b, busy_b, tx_done_b;
  logic [7:0] q_b[$];

  int checks = 0;
  int errors = 0;
  int rd_count_a = 0;
  int rd_count_b = 0;
  int done_count_a = 0;

  logic dut_sel = 1'b0;
  logic tx_mon, busy_mon, tx_done_mon;

  assign tx_mon      = dut_sel ? tx_b      : tx_a;
  assign busy_mon    = dut_sel ? busy_b    : busy_a;
  assign tx_done_mon = dut_sel ? tx_done_b : tx_done_a;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .fifo_empt  (fifo_empt_a),
    .fifo_data  (fifo_data_a),
    .fifo_rd_en (fifo_rd_en_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .tx_done    (tx_done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .fifo_empt  (fifo_empt_b),
    .fifo_data  (fifo_data_b),
    .fifo_rd_en (fifo_rd_en_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .tx_done    (tx_done_b)
  );

  always #5 clk = ~clk;

  // FIFO models: a read pops onto the data bus at the next edge, and the
  // empty flag is registered after any pop.
  always @(posedge clk) begin
    if (fifo_rd_en_a === 1'b1) begin
      rd_count_a <= rd_count_a + 1;
      if (q_a.size() > 0) fifo_data_a <= q_a.pop_front();
    end
    fifo_empt_a <= (q_a.size() == 0);
    if (tx_done_a === 1'b1) done_count_a <= done_count_a + 1;
  end

  always @(posedge clk) begin
    if (fifo_rd_en_b === 1'b1) begin
      rd_count_b <= rd_count_b + 1;
      if (q_b.size() > 0) fifo_data_b <= q_b.pop_front();
    end
    fifo_empt_b <= (q_b.size() == 0);
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_val, input int cycles);
    rst = rst_val;
    repeat (cycles) @(negedge clk);
  endtask

  // Waits for a start bit on the selected DUT (unless the caller has already
  // seen it on the current sample), then checks every cycle of the frame.
  // Finally it checks that the line is idle on the cycle after the frame.
  task automatic checkFrame(input string tag, input logic [7:0] data,
                            input int cpb, input bit started);
    logic [9:0] frame;
    int bad;
    int busy_bad;
    int done_bad;
    bit seen;
    frame    = {1'b1, data, 1'b0};
    busy_bad = 0;
    done_bad = 0;
    if (!started) begin
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (tx_mon === 1'b0) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput({tag, " start seen"}, 32'(seen), 32'd1);
      if (!seen) return;
    end
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < cpb; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (tx_mon !== frame[k]) bad++;
        if (busy_mon !== 1'b1) busy_bad++;
        if (tx_done_mon !== ((k == 9) && (c == cpb - 1))) done_bad++;
      end
      checkOutput($sformatf("%s bit%0d bad cycles", tag, k), 32'(bad), 32'd0);
    end
    checkOutput({tag, " busy drops"}, 32'(busy_bad), 32'd0);
    checkOutput({tag, " tx_done timing"}, 32'(done_bad), 32'd0);
    @(negedge clk);
    checkOutput({tag, " idle after frame tx"}, 32'(tx_mon), 32'd1);
    checkOutput({tag, " idle after frame busy"}, 32'(busy_mon), 32'd0);
  endtask

  initial begin
    int rd_base;
    int done_base;
    int gap;
    int bad;
    bit seen;

    $display("[TB] fifo_uart_tx directed test");

    // Reset is held for two edges while a byte is already waiting in the
    // FIFO. The DUT must stay quiet throughout.
    q_a.push_back(8'hA5);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset%0d tx", i), 32'(tx_a), 32'd1);
      checkOutput($sformatf("reset%0d rd_en", i), 32'(fifo_rd_en_a), 32'd0);
      checkOutput($sformatf("reset%0d busy", i), 32'(busy_a), 32'd0);
      checkOutput($sformatf("reset%0d tx_done", i), 32'(tx_done_a), 32'd0);
    end

    // Single byte A5 after release.
    rd_base   = rd_count_a;
    done_base = done_count_a;
    applyStimulus(1'b0, 0);
    checkFrame("A5", 8'hA5, 4, 1'b0);
    checkOutput("A5 rd pulses", 32'(rd_count_a - rd_base), 32'd1);
    checkOutput("A5 done pulses", 32'(done_count_a - done_base), 32'd1);

    // Empty FIFO for 100 cycles: nothing may happen.
    rd_base = rd_count_a;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checkOutput("empty idle cycles bad", 32'(bad), 32'd0);
    checkOutput("empty rd pulses", 32'(rd_count_a - rd_base), 32'd0);

    // Back-to-back frames 00 then FF. The gap is IDLE, REQ and WAIT.
    rd_base = rd_count_a;
    q_a.push_back(8'h00);
    q_a.push_back(8'hFF);
    checkFrame("B2B 00", 8'h00, 4, 1'b0);
    gap = 1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_a === 1'b0) begin
        seen = 1'b1;
        break;
      end
      gap++;
    end
    checkOutput("B2B second start seen", 32'(seen), 32'd1);
    checkOutput("B2B gap cycles", 32'(gap), 32'd3);
    if (seen) checkFrame("B2B FF", 8'hFF, 4, 1'b1);
    checkOutput("B2B rd pulses", 32'(rd_count_a - rd_base), 32'd2);

    // Mid-frame reset during DATA bit 3 of C3. Bit 3 of C3 is 0, so the
    // return to high is visible. Next, 3C must go out cleanly.
    q_a.push_back(8'hC3);
    q_a.push_back(8'h3C);
    done_base = done_count_a;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_a === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("abort start seen", 32'(seen), 32'd1);
    repeat (17) @(negedge clk);
    checkOutput("abort bit3 before reset", 32'(tx_a), 32'd0);
    applyStimulus(1'b1, 1);
    checkOutput("abort tx", 32'(tx_a), 32'd1);
    checkOutput("abort busy", 32'(busy_a), 32'd0);
    checkOutput("abort tx_done", 32'(tx_done_a), 32'd0);
    checkOutput("abort rd_en", 32'(fifo_rd_en_a), 32'd0);
    applyStimulus(1'b0, 0);
    checkOutput("abort done pulses", 32'(done_count_a - done_base), 32'd0);
    checkFrame("3C", 8'h3C, 4, 1'b0);
    checkOutput("3C done pulses", 32'(done_count_a - done_base), 32'd1);

    // CLKS_PER_BIT=2 instance with byte 81.
    dut_sel = 1'b1;
    rd_base = rd_count_b;
    q_b.push_back(8'h81);
    checkFrame("CPB2 81", 8'h81, 2, 1'b0);
    checkOutput("CPB2 rd pulses", 32'(rd_count_b - rd_base), 32'd1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 fifo_empt  input  1  upstream byte FIFO empty flag (registered in the FIFO).
REQ-006 fifo_data  input  8  upstream FIFO read data; valid from the cycle after the FIFO samples rd_en.
REQ-007 fifo_rd_en  output  1  read strobe to the upstream FIFO; registered.
REQ-008 tx  output  1  serial line, 8N1, idle high; registered.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 tx_done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-011 The state machine SHALL have the states IDLE, REQ, WAIT, START, DATA and STOP.
REQ-012 IDLE: tx=1 and fifo_rd_en=0; fifo_empt=0 sampled at an edge -> REQ; otherwise remain in IDLE.
REQ-013 fifo_empt SHALL be sampled only in IDLE.
REQ-014 REQ: fifo_rd_en=1 for exactly this one cycle -> WAIT.
REQ-015 WAIT: fifo_rd_en=0, one cycle; at the exiting edge, fifo_data is latched into an 8-bit shift register -> START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-017 DATA: 8 bits, LSB first, each held on tx for CLKS_PER_BIT cycles; a 3-bit bit index counts 0..7 -> STOP after bit 7.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 during the last cycle of STOP only -> IDLE.
REQ-019 Bit timing SHALL use a 16-bit down-counter:
- loaded with CLKS_PER_BIT-1 on entry to START, on each DATA bit and on STOP;
- the bit or state advances when the counter reaches 0.
REQ-020 The frame length from the first START cycle to the last STOP cycle SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-021 Back-to-back frames:
- after STOP, IDLE lasts 1 cycle, then REQ and WAIT follow;
- the minimum tx-high gap between stop bit and next start bit is 3 cycles;
- no other idle cycles are inserted while fifo_empt=0.
REQ-022 At most one fifo_rd_en pulse SHALL be issued per frame, so the upstream empty flag settles before the next sample.
REQ-023 fifo_data and fifo_empt SHALL be ignored in every state except as stated in REQ-012 and REQ-015.
REQ-024 The transmitted byte SHALL be unaffected by fifo_data changing after the WAIT latch.

Reset
REQ-025 In any cycle with rst=1, the next edge SHALL force:
- state=IDLE;
- tx=1, fifo_rd_en=0, busy=0, tx_done=0;
- counter=0, bit index=0, shift register=8'h00.
REQ-026 rst asserted mid-frame SHALL abort the frame (byte discarded, no tx_done); tx returns high at the next edge.
REQ-027 rst asserted in REQ or WAIT SHALL drop the fetched byte; no retry.
REQ-028 rst has priority over every other transition.

Verification
Benches use CLKS_PER_BIT=4 unless noted.
REQ-029 Reset: rst=1 for 2 cycles with fifo_empt=0 -> tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
REQ-030 Single byte 8'hA5 present, fifo_empt falls once:
- fifo_rd_en high 1 cycle; tx low 4 cycles;
- tx then carries bits 1,0,1,0,0,1,0,1, 4 cycles each;
- tx high 4 cycles, tx_done pulses once in the final cycle;
- the frame spans 40 cycles.
REQ-031 Back-to-back: FIFO holds 8'h00, 8'hFF with fifo_empt=0 -> two frames, a 3-cycle gap after the first stop bit, and exactly 2 fifo_rd_en pulses.
REQ-032 Empty FIFO: fifo_empt=1 for 100 cycles -> no fifo_rd_en pulse, tx=1, busy=0.
REQ-033 Mid-frame reset: rst=1 for 1 cycle during DATA bit 3 -> tx=1 next edge, busy=0, no tx_done; the next byte 8'h3C transmits correctly.
REQ-034 CLKS_PER_BIT=2, byte 8'h81 -> 20-cycle frame; the pattern 0,1,0,0,0,0,0,0,1,1 is held 2 cycles per bit.
